// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants and transforms: FK, arithmetic CK, S-box,
// the L' linear transform, tau, and the expansion FSM state type.
package sm4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } state_e;

    // FK[3] is FK0 so that the packed vector lines up with MK0 in the key's top word
    localparam logic [3:0][31:0] FK = {32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // CK byte j (j=0 most significant) of round i is ((4i+j)*7) mod 256
    function automatic logic [31:0] ck(input logic [4:0] i);
        logic [31:0] w;
        logic [7:0]  b;
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
            b = 8'(({3'd0, i} * 8'd4 + 8'(j)) * 8'd7);
            w = {w[23:0], b};
        end
        return w;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-schedule round: produces rk[r] and the shifted K window.
module sm4_key_round
    import sm4_pkg::*;
(
    input  logic [3:0][31:0] i_k,
    input  logic [4:0]       i_round,
    output logic [31:0]      o_rk,
    output logic [3:0][31:0] o_k
);

    logic [31:0] w_mix;

    // i_k[3] is K0, i_k[0] is K3
    assign w_mix = i_k[2] ^ i_k[1] ^ i_k[0] ^ ck(i_round);
    assign o_rk  = i_k[3] ^ l_key(tau(w_mix));
    assign o_k   = {i_k[2], i_k[1], i_k[0], o_rk};

endmodule

// File: rtl/sm4_key_schedule_mc.sv
// Multi-slot SM4 key expansion engine: FSM-driven schedule generation into a
// per-slot round-key store with registered encrypt/decrypt-order reads.
module sm4_key_schedule_mc
    import sm4_pkg::*;
#(
    parameter  int KEY_SLOTS        = 2,
    parameter  int ROUNDS_PER_CYCLE = 1,
    localparam int SLOT_W           = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [127:0]         i_key,
    input  logic [SLOT_W-1:0]    i_key_slot,
    input  logic                 i_key_valid,
    output logic                 o_key_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [KEY_SLOTS-1:0] o_slot_valid,
    input  logic                 i_rk_rd_en,
    input  logic [SLOT_W-1:0]    i_rk_rd_slot,
    input  logic [4:0]           i_rk_rd_idx,
    input  logic                 i_rk_rd_dec,
    output logic [31:0]          o_rk,
    output logic                 o_rk_valid
);

    localparam int         RPC        = ROUNDS_PER_CYCLE;
    localparam logic [4:0] LAST_ROUND = 5'(32 - RPC);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [SLOT_W-1:0]    r_slot;
    logic [127:0]         r_mk;
    logic [3:0][31:0]     r_k;
    logic [4:0]           r_round;
    logic [31:0]          r_mem [KEY_SLOTS][32];
    logic [KEY_SLOTS-1:0] r_slot_valid;
    logic                 r_key_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [31:0]          r_rk;
    logic                 r_rk_valid;

    logic                 w_accept;
    logic                 w_last;
    logic [3:0][31:0]     w_kc [RPC+1];
    logic [31:0]          w_rk [RPC];
    logic [4:0]           w_rd_idx;
    logic [31:0]          w_rd_word;
    logic                 w_rd_ok;

    assign w_accept = i_key_valid && r_key_ready;
    assign w_last   = (r_state == EXPAND) && (r_round == LAST_ROUND);
    assign w_kc[0]  = r_k;

    generate
        for (genvar g = 0; g < RPC; g++) begin : g_round
            sm4_key_round u_round (
                .i_k    (w_kc[g]),
                .i_round(r_round + 5'(g)),
                .o_rk   (w_rk[g]),
                .o_k    (w_kc[g+1])
            );
        end
    endgenerate

    // Next-state logic for the expansion sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = LOAD;
                else          w_state_nxt = IDLE;
            end
            LOAD:   w_state_nxt = EXPAND;
            EXPAND: begin
                if (w_last) w_state_nxt = DONE;
                else        w_state_nxt = EXPAND;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and registered status outputs; ready lags DONE by one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_key_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key_ready <= (r_state == IDLE) && (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt == LOAD) || (w_state_nxt == EXPAND);
            r_done      <= (r_state == DONE);
        end
    end

    // Key capture, whitening and round-chain advance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mk    <= 128'd0;
            r_slot  <= '0;
            r_k     <= '0;
            r_round <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mk   <= i_key;
                        r_slot <= i_key_slot;
                    end
                end
                LOAD: begin
                    r_k     <= r_mk ^ FK;
                    r_round <= 5'd0;
                end
                EXPAND: begin
                    r_k     <= w_kc[RPC];
                    r_round <= r_round + 5'(RPC);
                end
                default: r_k <= r_k;
            endcase
        end
    end

    // Round-key store; an out-of-range slot matches no row, so its schedule is dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < KEY_SLOTS; s++) begin
                for (int i = 0; i < 32; i++) begin
                    r_mem[s][i] <= 32'd0;
                end
            end
        end else if (r_state == EXPAND) begin
            for (int s = 0; s < KEY_SLOTS; s++) begin
                for (int p = 0; p < RPC; p++) begin
                    if (r_slot == SLOT_W'(s)) r_mem[s][r_round + 5'(p)] <= w_rk[p];
                end
            end
        end
    end

    // Slot usability flags: cleared on accept, set when the schedule completes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_valid <= '0;
        end else begin
            for (int s = 0; s < KEY_SLOTS; s++) begin
                if (w_accept && (i_key_slot == SLOT_W'(s)))       r_slot_valid[s] <= 1'b0;
                else if ((r_state == DONE) && (r_slot == SLOT_W'(s))) r_slot_valid[s] <= 1'b1;
            end
        end
    end

    // Read-port slot/index selection
    always_comb begin
        w_rd_idx  = i_rk_rd_dec ? (5'd31 - i_rk_rd_idx) : i_rk_rd_idx;
        w_rd_word = 32'd0;
        w_rd_ok   = 1'b0;
        for (int s = 0; s < KEY_SLOTS; s++) begin
            w_rd_word = w_rd_word | (r_mem[s][w_rd_idx] & {32{i_rk_rd_slot == SLOT_W'(s)}});
            w_rd_ok   = w_rd_ok | (r_slot_valid[s] & (i_rk_rd_slot == SLOT_W'(s)));
        end
    end

    // Registered read data; o_rk holds its value on an invalid read
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rk       <= 32'd0;
            r_rk_valid <= 1'b0;
        end else if (i_rk_rd_en && w_rd_ok) begin
            r_rk       <= w_rd_word;
            r_rk_valid <= 1'b1;
        end else begin
            r_rk_valid <= 1'b0;
        end
    end

    assign o_key_ready  = r_key_ready;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_slot_valid = r_slot_valid;
    assign o_rk         = r_rk;
    assign o_rk_valid   = r_rk_valid;

endmodule

// File: tb/tb_sm4_key_schedule_mc.sv
// Scoreboard bench: two engines (1 and 4 rounds/cycle) share stimulus and are
// checked against an algorithmic SM4 key-schedule model.
module tb_sm4_key_schedule_mc;

    localparam int KS = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [127:0]  key;
    logic [1:0]    key_slot;
    logic          key_valid;
    logic          rd_en;
    logic [1:0]    rd_slot;
    logic [4:0]    rd_idx;
    logic          rd_dec;
    logic          d1_ready, d1_busy, d1_done, d1_rkv;
    logic          d4_ready, d4_busy, d4_done, d4_rkv;
    logic [KS-1:0] d1_sv, d4_sv;
    logic [31:0]   d1_rk, d4_rk;

    typedef struct packed {
        logic        v;
        logic [31:0] rk;
        logic [7:0]  tag;
    } exp_t;

    exp_t          exp_q [$];
    int            tests;
    int            fails;
    int            cyc;
    int            t_acc;
    int            done1_at, done4_at, done1_cnt, done4_cnt, n_loads;
    logic [31:0]   last_rk;
    logic [KS-1:0] m_valid;
    logic [31:0]   m_rk [4][32];

    logic [31:0] fk [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    logic [7:0]  sb [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    always #5 clk = ~clk;

    sm4_key_schedule_mc #(.KEY_SLOTS(KS), .ROUNDS_PER_CYCLE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .i_key_slot(key_slot), .i_key_valid(key_valid),
        .o_key_ready(d1_ready), .o_busy(d1_busy), .o_done(d1_done), .o_slot_valid(d1_sv),
        .i_rk_rd_en(rd_en), .i_rk_rd_slot(rd_slot), .i_rk_rd_idx(rd_idx), .i_rk_rd_dec(rd_dec),
        .o_rk(d1_rk), .o_rk_valid(d1_rkv)
    );

    sm4_key_schedule_mc #(.KEY_SLOTS(KS), .ROUNDS_PER_CYCLE(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .i_key_slot(key_slot), .i_key_valid(key_valid),
        .o_key_ready(d4_ready), .o_busy(d4_busy), .o_done(d4_done), .o_slot_valid(d4_sv),
        .i_rk_rd_en(rd_en), .i_rk_rd_slot(rd_slot), .i_rk_rd_idx(rd_idx), .i_rk_rd_dec(rd_dec),
        .o_rk(d4_rk), .o_rk_valid(d4_rkv)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ck_m(input int i);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 4; j++) w = (w << 8) | 32'(((4 * i + j) * 7) % 256);
        return w;
    endfunction

    // Golden SM4 key expansion: K[i+4] = K[i] ^ T'(K[i+1]^K[i+2]^K[i+3]^CK[i])
    task automatic model_load(input int slot, input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) k[i] = mk[127 - 32 * i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_m(i);
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            k[i+4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
            m_rk[slot][i] = k[i+4];
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: counts cycles, records o_done pulses, and checks read responses
    task automatic monitor();
        logic pend;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            pend = rd_en;
            @(negedge clk);
            if (d1_done) begin done1_at = cyc; done1_cnt++; end
            if (d4_done) begin done4_at = cyc; done4_cnt++; end
            if (pend) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rd_unexpected: read response with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    if (!e.v) e.rk = last_rk;
                    if (d1_rkv !== e.v || d1_rk !== e.rk || d4_rkv !== e.v || d4_rk !== e.rk) begin
                        fails++;
                        $display("FAIL rd_%0d: got rpc1 v=%0b rk=%h rpc4 v=%0b rk=%h, expected v=%0b rk=%h",
                                 e.tag, d1_rkv, d1_rk, d4_rkv, d4_rk, e.v, e.rk);
                    end
                    last_rk = e.rk;
                end
            end
        end
    endtask

    task automatic rd(input logic [1:0] slot, input logic [4:0] idx, input logic dec,
                      input logic v, input logic [31:0] rk, input logic [7:0] tag);
        exp_t e;
        e.v = v; e.rk = rk; e.tag = tag;
        exp_q.push_back(e);
        rd_en = 1'b1; rd_slot = slot; rd_idx = idx; rd_dec = dec;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic rd_model(input logic [1:0] slot, input logic [4:0] idx, input logic dec, input logic [7:0] tag);
        logic v;
        v = (int'(slot) < KS) ? m_valid[slot] : 1'b0;
        rd(slot, idx, dec, v, m_rk[slot][dec ? (5'd31 - idx) : idx], tag);
    endtask

    task automatic start_load(input logic [1:0] slot, input logic [127:0] mk);
        int n;
        n = 0;
        while (!(d1_ready && d4_ready) && n < 100) begin tick(1); n++; end
        chk("ready_wait", 64'(n < 100), 64'd1);
        key = mk; key_slot = slot; key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        t_acc = cyc;
        n_loads++;
        if (int'(slot) < KS) m_valid[slot] = 1'b0;
        model_load(int'(slot), mk);
        chk("sv_on_accept_rpc1", 64'(d1_sv), 64'(m_valid));
        chk("sv_on_accept_rpc4", 64'(d4_sv), 64'(m_valid));
    endtask

    task automatic wait_done(input logic [1:0] slot);
        int n;
        n = 0;
        while ((done1_at <= t_acc || done4_at <= t_acc) && n < 80) begin tick(1); n++; end
        chk("done_latency_rpc1", 64'(done1_at - t_acc), 64'd34);
        chk("done_latency_rpc4", 64'(done4_at - t_acc), 64'd10);
        chk("done_count", 64'({done1_cnt, done4_cnt}), 64'({n_loads, n_loads}));
        if (int'(slot) < KS) m_valid[slot] = 1'b1;
        chk("sv_after_done_rpc1", 64'(d1_sv), 64'(m_valid));
        chk("sv_after_done_rpc4", 64'(d4_sv), 64'(m_valid));
    endtask

    initial begin
        logic [127:0] mk;
        logic [1:0]   s;
        int           c1, c4;
        tests = 0; fails = 0; cyc = 0; n_loads = 0;
        done1_at = -1; done4_at = -1; done1_cnt = 0; done4_cnt = 0;
        last_rk = 32'd0; m_valid = '0;
        rst_n = 1'b0; key = 128'd0; key_slot = 2'd0; key_valid = 1'b0;
        rd_en = 1'b0; rd_slot = 2'd0; rd_idx = 5'd0; rd_dec = 1'b0;
        fork
            monitor();
        join_none

        #2;
        chk("reset_outputs", {d1_ready, d1_busy, d1_done, d1_rkv, d1_sv, d1_rk, d4_ready, d4_busy, d4_done, d4_rkv, d4_sv, d4_rk}, 64'd0);
        #20 rst_n = 1'b1;
        tick(2);
        chk("ready_after_reset", {d1_ready, d4_ready}, 64'd3);

        // Standard vector into slot 0, then the same key into slot 1
        mk = 128'h0123456789ABCDEFFEDCBA9876543210;
        start_load(2'd0, mk);
        wait_done(2'd0);
        rd(2'd0, 5'd0,  1'b0, 1'b1, 32'hF12186F9, 8'd1);
        rd(2'd0, 5'd1,  1'b0, 1'b1, 32'h41662B61, 8'd2);
        rd(2'd0, 5'd31, 1'b0, 1'b1, 32'h9124A012, 8'd3);
        rd(2'd0, 5'd0,  1'b1, 1'b1, 32'h9124A012, 8'd4);
        rd(2'd0, 5'd31, 1'b1, 1'b1, 32'hF12186F9, 8'd5);
        start_load(2'd1, mk);
        wait_done(2'd1);
        rd(2'd1, 5'd0, 1'b0, 1'b1, 32'hF12186F9, 8'd6);
        rd_model(2'd0, 5'd17, 1'b0, 8'd7);

        // Busy: requests ignored, expanding slot unreadable, other slot readable
        start_load(2'd1, {$urandom, $urandom, $urandom, $urandom});
        key_valid = 1'b1; key_slot = 2'd0; key = 128'd0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("ready_low_busy", {d1_ready, d4_ready, d1_busy, d4_busy}, 64'h3);
        end
        key_valid = 1'b0;
        rd_model(2'd1, 5'd0, 1'b0, 8'd8);
        rd_model(2'd0, 5'd5, 1'b0, 8'd9);
        wait_done(2'd1);
        rd_model(2'd1, 5'd9, 1'b1, 8'd10);
        rd_model(2'd0, 5'd0, 1'b0, 8'd11);

        // Rewrite slot 0 with an all-zero master key
        start_load(2'd0, 128'd0);
        wait_done(2'd0);
        rd_model(2'd0, 5'd0, 1'b0, 8'd12);
        rd_model(2'd0, 5'd0, 1'b1, 8'd13);

        // Randomized loads, including the out-of-range slot 3, and random reads
        for (int it = 0; it < 6; it++) begin
            s = 2'($urandom_range(0, 3));
            start_load(s, {$urandom, $urandom, $urandom, $urandom});
            wait_done(s);
            for (int r = 0; r < 4; r++) begin
                rd_model(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 8'(20 + 4 * it + r));
            end
        end

        // Reset during expansion (round 10 of the 1-round/cycle engine)
        start_load(2'd2, {$urandom, $urandom, $urandom, $urandom});
        tick(11);
        c1 = done1_cnt;
        c4 = done4_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {d1_ready, d1_busy, d1_done, d1_rkv, d1_sv, d1_rk, d4_ready, d4_busy, d4_done, d4_rkv, d4_sv, d4_rk}, 64'd0);
        m_valid = '0;
        last_rk = 32'd0;
        tick(3);
        #3 rst_n = 1'b1;
        tick(40);
        chk("ready_after_midreset", {d1_ready, d4_ready}, 64'd3);
        chk("sv_after_midreset", {d1_sv, d4_sv}, 64'd0);
        chk("no_done_after_midreset", 64'({done1_cnt, done4_cnt}), 64'({c1, c4}));
        rd_model(2'd0, 5'd0, 1'b0, 8'd60);
        rd_model(2'd1, 5'd3, 1'b0, 8'd61);
        tick(2);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sm4_key_schedule_mc.md
Name: sm4_key_schedule_mc

Overview:
Parametrised, multi-slot SM4 key expansion engine. It runs autonomously: accepts one 128-bit master key, iterates all 32 key-schedule rounds under its own state machine (ROUNDS_PER_CYCLE rounds per clock), and stores the round keys in a per-slot register file. Cipher datapaths read round keys by index, in encrypt or decrypt order. It sits between the key-management/Ethernet config logic and one or more SM4 round pipelines. CK constants are generated arithmetically, so no init file is needed.

Parameters:
KEY_SLOTS, 2, number of independent stored key schedules (1..8)
ROUNDS_PER_CYCLE, 1, key-schedule rounds computed per clock (1, 2, 4 or 8; must divide 32)
SLOT_W, $clog2(KEY_SLOTS) min 1, slot index width (derived, localparam)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_key  in  128  master key MK0..MK3, with MK0 in [127:96]
i_key_slot  in  SLOT_W  destination slot for i_key
i_key_valid  in  1  key request
o_key_ready  out  1  engine idle; can accept a key
o_busy  out  1  expansion in progress
o_done  out  1  one-cycle pulse when a slot's schedule is complete
o_slot_valid  out  KEY_SLOTS  per-slot "schedule complete and usable" flag
i_rk_rd_en  in  1  round-key read strobe
i_rk_rd_slot  in  SLOT_W  slot to read
i_rk_rd_idx  in  5  round index 0..31
i_rk_rd_dec  in  1  1 = decrypt order (returns rk[31-idx])
o_rk  out  32  round key read data
o_rk_valid  out  1  read data valid

Behaviour:
- Clock, reset and polarity are fixed: one clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values:
  - o_key_ready=0 while i_rst_n low, then 1.
  - o_busy=0, o_done=0, o_slot_valid=0, o_rk=0, o_rk_valid=0.
  - Internal K0..K3, round counter and key storage are cleared to 0.
- Handshake: a key is accepted on a clock edge where i_key_valid && o_key_ready. i_key and i_key_slot are captured on that edge. Requests without ready are ignored; no queueing.
- FSM states and transitions: IDLE -> LOAD -> EXPAND -> DONE -> IDLE.
  - IDLE: o_key_ready=1. On accept, clear o_slot_valid[slot] on the same edge, then go to LOAD.
  - LOAD (1 cycle): K0..K3 <= MK0..MK3 xor FK0..FK3, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC. Round counter r=0.
  - EXPAND (32/ROUNDS_PER_CYCLE cycles): ROUNDS_PER_CYCLE rounds are chained combinationally each cycle. One round is:
    - rk[r] = K0 ^ L'(tau(K1^K2^K3^CK[r])).
    - L'(B) = B ^ (B<<<13) ^ (B<<<23).
    - tau applies the SM4 S-box bytewise.
    - Shift: K0<=K1, K1<=K2, K2<=K3, K3<=rk[r].
    - Each rk is written to slot storage at index r, and r advances by ROUNDS_PER_CYCLE.
    - Leave EXPAND when the write of rk[31] occurs.
  - DONE (1 cycle): o_done=1 and o_slot_valid[slot] set. Then return to IDLE.
  - o_busy=1 in LOAD and EXPAND.
- CK constants: byte j (j=0 is MSB) of CK[i] = ((4i+j)*7) mod 256.
- Latency: accept at edge T. o_done is high in cycle T+2+32/ROUNDS_PER_CYCLE, which is cycle T+34 for RPC=1. o_key_ready returns in the following cycle.
- Reads:
  - Registered, 1-cycle latency, independent of the FSM.
  - Effective index = i_rk_rd_dec ? 31-idx : idx.
  - If o_slot_valid[rd_slot]=1: o_rk = stored key and o_rk_valid=1.
  - Otherwise: o_rk_valid=0 and o_rk holds its previous value.
  - A read of the slot being expanded is therefore never valid. Other slots stay readable during expansion.
- Out-of-range slot index (slot >= KEY_SLOTS): a key request is still accepted, but the result is discarded and no flag is set, though o_done still pulses. A read returns o_rk_valid=0.
- Same-slot rewrite: a new key to an already valid slot invalidates it on accept. The old schedule is lost.
- Reset mid-expansion: immediate return to IDLE; all slot flags cleared; no o_done.

Decomposition:
- Package sm4_pkg holds:
  - the FK constant array;
  - a function ck(i) returning CK[i];
  - the 256-entry S-box constant and function sbox(byte);
  - functions l_key(word) (the L' transform) and tau(word);
  - the state enum {IDLE, LOAD, EXPAND, DONE}.
- Sub-module sm4_key_round: one purely combinational round, with inputs K0..K3 and round index, outputs rk and new K. It is instantiated ROUNDS_PER_CYCLE times in a generate chain. Storage and FSM stay in the top module.

Test Plan:
1. Standard key vector, RPC=1, slot 0: MK=0123456789ABCDEFFEDCBA9876543210 -> o_done at T+34; reading idx 0 gives F12186F9, idx 1 gives 41662B61, idx 31 gives 9124A012.
2. Same key, RPC=4, slot 1 -> o_done at T+10; the stored schedule is identical to scenario 1; slot 0 remains valid.
3. Decrypt-order read: slot 0, idx 0 with i_rk_rd_dec=1 -> o_rk=9124A012 one cycle after the strobe; idx 31 with dec=1 -> F12186F9.
4. Busy behaviour:
   - i_key_valid held during EXPAND -> ignored, o_key_ready=0.
   - A read of the expanding slot returns o_rk_valid=0, and a read of another valid slot returns valid data.
5. Rewrite: reload slot 0 with all-zero MK -> o_slot_valid[0] drops on the accept edge and rises at o_done; rk0 then differs from F12186F9 and matches the golden model.
6. Drive i_rst_n low at EXPAND round 10 -> all outputs are 0 asynchronously; after release o_key_ready=1, o_slot_valid=0, and no o_done pulse.
